i2c_reg_target: RTL
===================

Name: i2c_reg_target

Overview:
- I2C target (responder) that models a codec control port with a 16-bit register address map.
- Accepts multi-byte writes with auto-increment, the same sub-addressed sequence the codec init master issues: device address, register address high byte, register address low byte, then data bytes.
- Supports pointer-set-then-repeated-start reads.
- Used as a bus-functional target in system benches, and as an on-chip shadow of codec configuration.

Parameters:
- DEV_ADDR, 7'h3B, 7-bit device address to acknowledge.
- ADDR_BITS, 8, log2 of internal byte register file depth.
- REG_BASE, 16'h4000, first stored register address; must be aligned to 2^ADDR_BITS.

Ports:
- clk  in  1  system clock; must be at least 20x the SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL pin input (asynchronous).
- sda_i  in  1  SDA pin input (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- busy  out  1  high from START to STOP.
- wr_stb  out  1  one-cycle pulse per data byte written.
- wr_addr  out  16  register address of the byte just written.
- wr_data  out  8  data of the byte just written.
- rd_addr  in  ADDR_BITS  local read index into the register file.
- rd_data  out  8  regs[rd_addr], registered, 1-cycle latency.

Behaviour:
- Input conditioning: scl_i and sda_i each pass through a 2-flop synchronizer plus a previous-value register. All edges are detected on synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- START from any state (including repeated start): go to DEV, clear bit counter, set busy=1.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- Bit sampling and drive timing:
  - SDA is sampled on SCL rising edge, MSB first.
  - sda_oe changes only on SCL falling edge.
  - sda_oe changes 1 clk after the synchronized falling edge.
- States and transitions:
  - IDLE: ignore bus until START.
  - DEV: shift 8 bits. At the 8th falling edge:
    - address == DEV_ADDR: ACK (sda_oe=1); go to ACK_DEV.
    - otherwise: go to IDLE without ACK.
    - Record the R/W bit.
  - ACK_DEV: at the next falling edge, release SDA.
    - W: go to ADDR_HI.
    - R: load shift register from current pointer; go to RDATA.
  - ADDR_HI / ADDR_LO: shift 8 bits, ACK, then load ptr[15:8] / ptr[7:0] respectively. ADDR_LO is followed by WDATA.
  - WDATA: shift 8 bits. At the 8th falling edge:
    - ACK.
    - Pulse wr_stb with wr_addr=ptr and wr_data=byte.
    - Store the byte if in range.
    - ptr increments modulo 2^16 (0xFFFF wraps to 0x0000).
    - Repeat WDATA.
  - RDATA: drive sda_oe = ~bit, MSB first, with each bit presented on a falling edge. After 8 bits, release SDA for the master ACK bit and go to RACK.
  - RACK: sample on SCL rising edge.
    - 0 (ACK): ptr++, reload, back to RDATA.
    - 1 (NACK): go to IDLE-wait; do not drive until START.
- Range rule:
  - In range means ptr[15:ADDR_BITS] == REG_BASE[15:ADDR_BITS]; index is ptr[ADDR_BITS-1:0].
  - Out-of-range writes are still ACKed and still pulse wr_stb, but are not stored.
  - Out-of-range reads return 0x00.
- The pointer persists across transactions until rewritten or reset.
- Reset values:
  - sda_oe=0, busy=0, wr_stb=0, wr_addr=0, wr_data=0, rd_data=0, ptr=0.
  - All register file bytes = 0x00; state = IDLE.
- Reset mid-transaction: the bus is released at the reset edge, and nothing is driven until a fresh START is seen.
- Simultaneous events: a START/STOP detection takes priority over bit processing in the same cycle.

Test Plan:
- Write transaction: 0x76, 0x40, 0x15, 0x01 → target ACKs all 4 bytes; exactly one wr_stb with wr_addr=0x4015, wr_data=0x01; rd_addr=0x15 gives rd_data=0x01.
- Burst write at 0x4002 of 7D 00 0C 21 01 → 5 wr_stb pulses at addresses 0x4002..0x4006; regs[0x02..0x06] hold those values.
- Device address 0x74 (7'h3A) → no ACK, sda_oe stays 0 for the whole transaction, no wr_stb; busy drops at STOP.
- Random read: write pointer 0x4015, repeated start, 0x77, read 2 bytes with master ACK then NACK → bytes 0x01 then regs[0x16]; sda_oe=0 after the NACK.
- Out of range and wrap:
  - Write 0xAA at 0x5000 → ACKed, wr_stb pulses, not stored; a read from 0x5000 returns 0x00.
  - Write 2 bytes at 0xFFFF → wr_addr 0xFFFF then 0x0000.
- Assert rst for 1 clk during the 5th bit of a data byte → sda_oe=0, busy=0; remaining SCL pulses are ignored and the next START+0x76 is ACKed normally.

Source files
------------

// File: rtl/i2c_reg_target.sv
// I2C target exposing a 16-bit sub-addressed register map with auto-increment,
// backed by a 2^ADDR_BITS byte register file located at REG_BASE.
module i2c_reg_target #(
    parameter logic [6:0]  DEV_ADDR  = 7'h3B,
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [15:0] REG_BASE  = 16'h4000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_oe,
    output logic                 busy,
    output logic                 wr_stb,
    output logic [15:0]          wr_addr,
    output logic [7:0]           wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_ACK_DEV, S_ADDR_HI, S_ACK_HI, S_ADDR_LO, S_ACK_LO,
        S_WDATA, S_ACK_WR, S_RDATA, S_RACK
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_prev_q, sda_prev_q;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    state_t      state_q, state_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        rw_q, rw_d;
    logic [15:0] ptr_q, ptr_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_stb_q, wr_stb_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [7:0]  rd_data_q;

    logic [7:0]  regs_q [DEPTH];
    logic        reg_we;
    logic [ADDR_BITS-1:0] reg_widx;
    logic [7:0]  reg_wdata;

    logic [15:0] nxt_ptr;
    logic        ptr_in_range, nxt_in_range;
    logic [7:0]  ptr_byte, nxt_byte;

    // Synchronizer is left unreset so a reset with SCL high never fakes a START/STOP edge.
    always_ff @(posedge clk) begin
        scl_sync_q <= {scl_sync_q[0], scl_i};
        sda_sync_q <= {sda_sync_q[0], sda_i};
        scl_prev_q <= scl_sync_q[1];
        sda_prev_q <= sda_sync_q[1];
    end

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign nxt_ptr      = ptr_q + 16'd1;
    assign ptr_in_range = (ptr_q[15:ADDR_BITS] == REG_BASE[15:ADDR_BITS]);
    assign nxt_in_range = (nxt_ptr[15:ADDR_BITS] == REG_BASE[15:ADDR_BITS]);
    assign ptr_byte     = ptr_in_range ? regs_q[ptr_q[ADDR_BITS-1:0]] : 8'h00;
    assign nxt_byte     = nxt_in_range ? regs_q[nxt_ptr[ADDR_BITS-1:0]] : 8'h00;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        reg_widx  = ptr_q[ADDR_BITS-1:0];
        reg_wdata = rx_q;

        if (start_det) begin
            state_d  = S_DEV;
            bitcnt_d = '0;
            busy_d   = 1'b1;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                S_DEV, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
                    if (scl_rise && bitcnt_q != 4'd8) begin
                        rx_d     = {rx_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        case (state_q)
                            S_DEV: begin
                                rw_d = rx_q[0];
                                if (rx_q[7:1] == DEV_ADDR) begin
                                    sda_oe_d = 1'b1;
                                    state_d  = S_ACK_DEV;
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                            S_ADDR_HI: begin
                                ptr_d[15:8] = rx_q;
                                sda_oe_d    = 1'b1;
                                state_d     = S_ACK_HI;
                            end
                            S_ADDR_LO: begin
                                ptr_d[7:0] = rx_q;
                                sda_oe_d   = 1'b1;
                                state_d    = S_ACK_LO;
                            end
                            default: begin
                                sda_oe_d  = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_q;
                                reg_we    = ptr_in_range;
                                ptr_d     = nxt_ptr;
                                state_d   = S_ACK_WR;
                            end
                        endcase
                    end
                end
                S_ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            // First read bit goes out on the same edge that ends the ACK.
                            sda_oe_d = ~ptr_byte[7];
                            tx_d     = {ptr_byte[6:0], 1'b0};
                            bitcnt_d = 4'd1;
                            state_d  = S_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                            state_d  = S_ADDR_HI;
                        end
                    end
                end
                S_ACK_HI, S_ACK_LO, S_ACK_WR: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = '0;
                        state_d  = (state_q == S_ACK_HI) ? S_ADDR_LO : S_WDATA;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RACK;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d    = nxt_ptr;
                            tx_d     = nxt_byte;
                            bitcnt_d = '0;
                            state_d  = S_RDATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bitcnt_q  <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            if (reg_we) begin
                regs_q[reg_widx] <= reg_wdata;
            end
            rd_data_q <= regs_q[rd_addr];
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_data = rd_data_q;

endmodule
